// File: rtl/llio_snes_pad_if.sv
// Bundle between the LLIO receiver / core side and the emulated SNES pad.
// Signal directions are named from the pad's point of view (i_ into the pad, o_ out of it).
interface llio_snes_pad_if;
    logic        i_llio_en;
    logic [7:0]  i_llio_type;
    logic [23:0] i_llio_buttons;
    logic [47:0] i_llio_analog;
    logic        i_pad_latch;
    logic        i_pad_clk;
    logic        o_pad_data;
    logic        o_poll_strobe;

    modport master (
        output i_llio_en,
        output i_llio_type,
        output i_llio_buttons,
        output i_llio_analog,
        output i_pad_latch,
        output i_pad_clk,
        input  o_pad_data,
        input  o_poll_strobe
    );

    modport slave (
        input  i_llio_en,
        input  i_llio_type,
        input  i_llio_buttons,
        input  i_llio_analog,
        input  i_pad_latch,
        input  i_pad_clk,
        output o_pad_data,
        output o_poll_strobe
    );
endinterface

// File: rtl/llio_snes_pad.sv
// Emulated SNES serial pad fed from the LLIO receiver: maps buttons (plus optional analog
// D-pad folding and SOCD cleaning) into a 16-bit active-low word shifted out LSB first.
module llio_snes_pad #(
    parameter bit         ANALOG_DPAD = 1'b1,
    parameter logic [7:0] AXIS_LO     = 8'd50,
    parameter logic [7:0] AXIS_HI     = 8'd200,
    parameter bit         SOCD_CLEAN  = 1'b1
) (
    input  logic           i_clk_50m,
    input  logic           i_reset,
    llio_snes_pad_if.slave pad_if
);

    typedef enum logic {
        ST_LOAD,
        ST_SHIFT
    } state_t;

    localparam logic [4:0] BIT_COUNT_MAX = 5'd16;

    logic        r_latch_meta;
    logic        r_latch_sync;
    logic        r_latch_dly;
    logic        r_clk_meta;
    logic        r_clk_sync;
    logic        r_clk_dly;
    logic [15:0] r_shift;
    logic [4:0]  r_count;

    logic [7:0]  w_axis_x;
    logic [7:0]  w_axis_y;
    logic        w_up_raw;
    logic        w_down_raw;
    logic        w_left_raw;
    logic        w_right_raw;
    logic        w_up;
    logic        w_down;
    logic        w_left;
    logic        w_right;
    logic        w_enable;
    logic [11:0] w_pressed;
    logic [15:0] w_load_word;
    logic        w_clk_rise;
    state_t      w_state;
    logic        w_unused;

    assign w_axis_x = pad_if.i_llio_analog[7:0];
    assign w_axis_y = pad_if.i_llio_analog[15:8];

    // Buttons and axis bits the SNES pad has no use for.
    assign w_unused = ^{pad_if.i_llio_buttons[23:14], pad_if.i_llio_buttons[9:8],
                        pad_if.i_llio_analog[47:16]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_up_raw    = pad_if.i_llio_buttons[10] | (ANALOG_DPAD && (w_axis_y < AXIS_LO));
        w_down_raw  = pad_if.i_llio_buttons[11] | (ANALOG_DPAD && (w_axis_y > AXIS_HI));
        w_left_raw  = pad_if.i_llio_buttons[12] | (ANALOG_DPAD && (w_axis_x < AXIS_LO));
        w_right_raw = pad_if.i_llio_buttons[13] | (ANALOG_DPAD && (w_axis_x > AXIS_HI));

        w_up    = w_up_raw;
        w_down  = w_down_raw;
        w_left  = w_left_raw;
        w_right = w_right_raw;
        if (SOCD_CLEAN) begin
            if (w_up_raw && w_down_raw) begin
                w_up   = 1'b0;
                w_down = 1'b0;
            end
            if (w_left_raw && w_right_raw) begin
                w_left  = 1'b0;
                w_right = 1'b0;
            end
        end

        w_enable  = pad_if.i_llio_en && (pad_if.i_llio_type != 8'd0);
        w_pressed = 12'd0;
        if (w_enable) begin
            // SNES shift order, LSB first: B Y Sel Start U D Lf Rt A X L R.
            w_pressed = {pad_if.i_llio_buttons[7],  pad_if.i_llio_buttons[6],
                         pad_if.i_llio_buttons[2],  pad_if.i_llio_buttons[3],
                         w_right, w_left, w_down, w_up,
                         pad_if.i_llio_buttons[5],  pad_if.i_llio_buttons[4],
                         pad_if.i_llio_buttons[0],  pad_if.i_llio_buttons[1]};
        end
        w_load_word = {4'hF, ~w_pressed};
    end

    // The FSM state is the synchronized latch itself; no separate state flop keeps the
    // pin-to-data latency at exactly 3 cycles.
    assign w_state    = r_latch_sync ? ST_LOAD : ST_SHIFT;
    assign w_clk_rise = r_clk_sync & ~r_clk_dly;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values and the sync chain really is three stages deep.
    always_ff @(posedge i_clk_50m) begin
        if (i_reset) begin
            r_latch_meta <= 1'b0;
            r_latch_sync <= 1'b0;
            r_latch_dly  <= 1'b0;
            r_clk_meta   <= 1'b0;
            r_clk_sync   <= 1'b0;
            r_clk_dly    <= 1'b0;
            r_shift      <= 16'hFFFF;
            r_count      <= 5'd0;
        end else begin
            r_latch_meta <= pad_if.i_pad_latch;
            r_latch_sync <= r_latch_meta;
            r_latch_dly  <= r_latch_sync;
            r_clk_meta   <= pad_if.i_pad_clk;
            r_clk_sync   <= r_clk_meta;
            r_clk_dly    <= r_clk_sync;

            case (w_state)
                ST_LOAD: begin
                    r_shift <= w_load_word;
                    r_count <= 5'd0;
                end
                ST_SHIFT: begin
                    // Once 16 bits are out only zeros remain, so stopping here matches a real pad.
                    if (w_clk_rise && (r_count != BIT_COUNT_MAX)) begin
                        r_shift <= {1'b0, r_shift[15:1]};
                        r_count <= r_count + 5'd1;
                    end
                end
                default: begin
                    r_shift <= 16'hFFFF;
                    r_count <= 5'd0;
                end
            endcase
        end
    end

    assign pad_if.o_pad_data    = r_shift[0];
    assign pad_if.o_poll_strobe = ~r_latch_sync & r_latch_dly;

endmodule

// File: tb/tb_llio_snes_pad.sv
// Directed bench for llio_snes_pad: three instances (default, no analog folding, no SOCD
// cleaning) see the same stimulus; table vectors plus multi-cycle corner sequences.
module tb_llio_snes_pad;

    typedef struct {
        string       name;
        logic        en;
        logic [7:0]  typ;
        logic [23:0] buttons;
        logic [47:0] analog;
        logic [15:0] exp_def;
        logic [15:0] exp_nan;
        logic [15:0] exp_nsocd;
    } vec_t;

    localparam logic [47:0] CENTER = 48'h0000_0000_8080;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  typ = 8'd0;
    logic [23:0] buttons = 24'd0;
    logic [47:0] analog = CENTER;
    logic        latch = 1'b0;
    logic        pclk = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_strobe = 0;

    logic [17:0] got0, got1, got2;

    llio_snes_pad_if if0 ();
    llio_snes_pad_if if1 ();
    llio_snes_pad_if if2 ();

    assign if0.i_llio_en = en;      assign if1.i_llio_en = en;      assign if2.i_llio_en = en;
    assign if0.i_llio_type = typ;   assign if1.i_llio_type = typ;   assign if2.i_llio_type = typ;
    assign if0.i_llio_buttons = buttons;
    assign if1.i_llio_buttons = buttons;
    assign if2.i_llio_buttons = buttons;
    assign if0.i_llio_analog = analog;
    assign if1.i_llio_analog = analog;
    assign if2.i_llio_analog = analog;
    assign if0.i_pad_latch = latch; assign if1.i_pad_latch = latch; assign if2.i_pad_latch = latch;
    assign if0.i_pad_clk = pclk;    assign if1.i_pad_clk = pclk;    assign if2.i_pad_clk = pclk;

    llio_snes_pad dut_def (
        .i_clk_50m (clk),
        .i_reset   (rst),
        .pad_if    (if0.slave)
    );

    llio_snes_pad #(.ANALOG_DPAD(1'b0)) dut_nan (
        .i_clk_50m (clk),
        .i_reset   (rst),
        .pad_if    (if1.slave)
    );

    llio_snes_pad #(.SOCD_CLEAN(1'b0)) dut_nsocd (
        .i_clk_50m (clk),
        .i_reset   (rst),
        .pad_if    (if2.slave)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (if0.o_poll_strobe === 1'b1) n_strobe++;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_latch();
        @(negedge clk);
        latch = 1'b1;
        wait_neg(4);
        latch = 1'b0;
        wait_neg(4);
    endtask

    task automatic clk_pulse();
        pclk = 1'b1;
        wait_neg(4);
        pclk = 1'b0;
        wait_neg(4);
    endtask

    // Sample i is taken after i pad clocks.
    task automatic read_bits(input int from, input int to);
        for (int i = from; i < to; i++) begin
            @(negedge clk);
            got0[i] = if0.o_pad_data;
            got1[i] = if1.o_pad_data;
            got2[i] = if2.o_pad_data;
            clk_pulse();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_neg(3);
        rst = 1'b0;
        wait_neg(1);
    endtask

    vec_t vecs[11];
    int   strobe_before;

    initial begin
        //          name            en    typ    buttons       analog               def       nan       nsocd
        vecs[0]  = '{"b_only",      1'b1, 8'd27, 24'h000002,   CENTER,              16'hFFFE, 16'hFFFE, 16'hFFFE};
        vecs[1]  = '{"st_a_d",      1'b1, 8'd27, 24'h000828,   CENTER,              16'hFED7, 16'hFED7, 16'hFED7};
        vecs[2]  = '{"analog_left", 1'b1, 8'd27, 24'h000000,   48'h0000_0000_800A,  16'hFFBF, 16'hFFFF, 16'hFFBF};
        vecs[3]  = '{"socd_lr",     1'b1, 8'd27, 24'h003000,   CENTER,              16'hFFFF, 16'hFFFF, 16'hFF3F};
        vecs[4]  = '{"en_off",      1'b0, 8'd27, 24'hFFFFFF,   CENTER,              16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[5]  = '{"type_zero",   1'b1, 8'd0,  24'hFFFFFF,   CENTER,              16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[6]  = '{"all_pressed", 1'b1, 8'd27, 24'hFFFFFF,   CENTER,              16'hF0F0, 16'hF0F0, 16'hF000};
        vecs[7]  = '{"analog_rt_u", 1'b1, 8'd27, 24'h000000,   48'h0000_0000_14FA,  16'hFF6F, 16'hFFFF, 16'hFF6F};
        vecs[8]  = '{"axis_edge",   1'b1, 8'd27, 24'h000000,   48'h0000_0000_C832,  16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[9]  = '{"axis_past",   1'b1, 8'd27, 24'h000000,   48'h0000_0000_C931,  16'hFF9F, 16'hFFFF, 16'hFF9F};
        vecs[10] = '{"socd_mixed",  1'b1, 8'd27, 24'h000800,   48'h0000_0000_0A80,  16'hFFFF, 16'hFFDF, 16'hFFCF};

        do_reset();
        check("reset_data_def",   32'(if0.o_pad_data),    32'd1);
        check("reset_data_nan",   32'(if1.o_pad_data),    32'd1);
        check("reset_strobe",     32'(if0.o_poll_strobe), 32'd0);

        // Latch rise to data change: still old value after 2 edges, new value after the 3rd.
        en = 1'b1; typ = 8'd27; buttons = 24'h000002; analog = CENTER;
        @(posedge clk); #1 latch = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 check("latency_2cyc", 32'(if0.o_pad_data), 32'd1);
        @(posedge clk); #1 check("latency_3cyc", 32'(if0.o_pad_data), 32'd0);
        wait_neg(3);
        latch = 1'b0;
        wait_neg(4);
        read_bits(0, 16);
        check("latency_word", 32'(got0[15:0]), 32'hFFFE);

        for (int v = 0; v < 11; v++) begin
            en = vecs[v].en; typ = vecs[v].typ;
            buttons = vecs[v].buttons; analog = vecs[v].analog;
            do_latch();
            read_bits(0, 18);
            check({vecs[v].name, "_def"},   32'(got0[15:0]), 32'(vecs[v].exp_def));
            check({vecs[v].name, "_nan"},   32'(got1[15:0]), 32'(vecs[v].exp_nan));
            check({vecs[v].name, "_nsocd"}, 32'(got2[15:0]), 32'(vecs[v].exp_nsocd));
            check({vecs[v].name, "_tail"},  32'(got0[17:16]), 32'd0);
        end

        // Buttons change mid-shift: the frozen word keeps shifting.
        en = 1'b1; typ = 8'd27; buttons = 24'h000828; analog = CENTER;
        do_latch();
        read_bits(0, 4);
        buttons = 24'hFFFFFF;
        read_bits(4, 16);
        check("freeze_buttons", 32'(got0[15:0]), 32'hFED7);

        // Device drops mid-shift: release only shows at the next latch.
        buttons = 24'h000828;
        do_latch();
        read_bits(0, 2);
        en = 1'b0;
        read_bits(2, 16);
        check("freeze_en_drop", 32'(got0[15:0]), 32'hFED7);
        do_latch();
        read_bits(0, 16);
        check("en_drop_next_load", 32'(got0[15:0]), 32'hFFFF);

        // Clock pulse inside the latch window is ignored.
        en = 1'b1; buttons = 24'h000002;
        @(negedge clk);
        latch = 1'b1;
        wait_neg(4);
        clk_pulse();
        latch = 1'b0;
        wait_neg(4);
        read_bits(0, 16);
        check("clk_in_latch", 32'(got0[15:0]), 32'hFFFE);

        // Exactly one strobe per latch.
        strobe_before = n_strobe;
        do_latch();
        check("strobe_one", 32'(n_strobe - strobe_before), 32'd1);
        strobe_before = n_strobe;
        do_latch();
        do_latch();
        check("strobe_two", 32'(n_strobe - strobe_before), 32'd2);

        // Reset mid-read after 5 clocks.
        buttons = 24'h000828;
        do_latch();
        read_bits(0, 5);
        @(negedge clk);
        check("pre_reset_bit5", 32'(if0.o_pad_data), 32'd0);
        do_reset();
        check("post_reset_def",   32'(if0.o_pad_data), 32'd1);
        check("post_reset_nsocd", 32'(if2.o_pad_data), 32'd1);
        check("post_reset_strobe", 32'(if0.o_poll_strobe), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
